mod_exp_engine: RTL and testbench
=================================

Name: mod_exp_engine

Overview:
- Parametrised modular exponentiator computing value_in^exponent_in mod modulus_in.
- Next generation of the crypto datapath exponent block:
  - exponent width independent of operand width
  - left-to-right square-and-multiply that skips leading zeros
  - full base reduction, including base ≥ modulus
  - abort, and error reporting for a zero modulus
- All modular products come from one bit-serial interleaved modular multiplier, so there are no 2*WIDTH intermediates.

Parameters:
- WIDTH, 16, width of base, modulus and result
- EXP_WIDTH, 16, width of exponent

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-high reset
- ready_in  input  1  start request; sampled only while idle
- abort_in  input  1  cancel the operation in progress
- value_in  input  WIDTH  base
- modulus_in  input  WIDTH  modulus
- exponent_in  input  EXP_WIDTH  exponent
- value_out  output  WIDTH  result; holds until the next completion
- busy_out  output  1  operation in progress
- valid_out  output  1  one-cycle completion pulse
- error_out  output  1  last request had modulus 0; held until the next accepted start

Behaviour:
- Reset: one clock, clk_in. Asynchronous active-high reset rst_in clears all state:
  - value_out=0, busy_out=0, valid_out=0, error_out=0, FSM=IDLE.
  - Reset mid-operation discards the operation and emits no valid_out.
- Accept: in IDLE, ready_in=1 latches value_in, modulus_in and exponent_in into internal registers.
  - Later input changes have no effect.
  - busy_out=1 from the next cycle.
  - ready_in while busy is ignored.
- Setup in the accept cycle: a combinational priority encoder gives k = index of the exponent MSB. Special cases:
  - modulus=0: the next cycle goes to DONE with value_out=0, error_out=1.
  - exponent=0: the next cycle goes to DONE with value_out = (m==1 ? 0 : 1).
- FSM: IDLE -> REDUCE -> {SQUARE -> [MULT]}* -> DONE -> IDLE.
- REDUCE: B = modmul(a=(m==1?0:1), b=value_in), i.e. value_in mod m. acc=B, i=k-1.
- SQUARE: acc = modmul(acc, acc).
  - Then if exp[i]=1 go to MULT.
  - Otherwise decrement i, or go to DONE if i was 0.
- MULT: acc = modmul(acc, B). Then decrement i, or go to DONE if i was 0.
- DONE (one cycle):
  - value_out <= acc (or the special-case value).
  - valid_out=1 and busy_out=0 in the same cycle.
  - Return to IDLE.
  - ready_in in the DONE cycle is ignored.
- modmul sub-operation (cost WIDTH+2 cycles in the top FSM):
  - 1 issue cycle (start pulse).
  - WIDTH iteration cycles, MSB to LSB of b: acc2 = 2*acc2 mod m; if b[j], acc2 = acc2 + a mod m.
  - Each step uses one conditional subtract on a WIDTH+1 bit intermediate. Requires a < m and m ≥ 1.
  - 1 capture cycle on the done pulse.
- Latency: valid_out occurs exactly L cycles after the ready_in sample cycle, with L = 2 + (WIDTH+2)*(1 + k + popcount(exp) - 1).
  - Special cases: L = 2.
- Abort: abort_in=1 while busy forces IDLE on the next edge.
  - busy_out=0; no valid_out; value_out and error_out unchanged.
  - The modmul is cleared.
  - If abort_in and DONE coincide, the completion wins.
- Arithmetic: m=1 gives result 0 for every exponent. Full-range operands (all ones) must not overflow.

Decomposition:
- Package mod_exp_pkg holds:
  - state enum (IDLE, REDUCE, SQUARE, MULT, DONE)
  - op-select enum for the modmul operand mux
  - cycle-cost constant function for the bench
- Sub-module mod_mul_serial: interleaved a*b mod m, WIDTH-parametrised.
  - Ports: start/done pulse, a, b, m, result.
  - Has a synchronous clear used by abort.

Test Plan:
- WIDTH=16: 4^13 mod 497 -> value_out=445. valid_out pulses exactly 110 cycles after ready_in; busy_out falls in the same cycle.
- 1000^2 mod 7 (base ≥ modulus) -> 1. Then 3^0 mod 7 -> 1 with L=2. Then 5^9 mod 1 -> 0.
- modulus=0, any base/exponent -> value_out=0, error_out=1 at L=2. The next valid request clears error_out.
- Start 65535^65535 mod 65521, assert abort_in mid-SQUARE -> busy_out=0 next cycle, no valid_out, value_out keeps its previous value. A new request then completes correctly against the reference model.
- ready_in re-pulsed and inputs changed while busy -> ignored; the result matches the originally latched operands. rst_in asserted mid-operation -> all outputs 0 immediately, without waiting for a clock edge.
- Random regression with WIDTH=24, EXP_WIDTH=32 -> every result and latency matches the modpow model and the L formula.

Source files
------------

// File: rtl/mod_exp_pkg.sv
// Shared types and helpers for the modular exponentiation engine.
package mod_exp_pkg;

  typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;

  typedef enum logic [1:0] {OP_REDUCE, OP_SQUARE, OP_MULT} op_sel_t;

  // Cycles from the ready_in sample cycle to the valid_out cycle.
  // msb is the exponent MSB index and ones is the exponent popcount.
  function automatic int unsigned cycle_cost(input int unsigned width,
                                             input int unsigned msb,
                                             input int unsigned ones,
                                             input bit special);
    return special ? 2 : 2 + (width + 2) * (msb + ones);
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: result = a*b mod m, b scanned MSB first.
// Needs a < m and m >= 1. Latency is WIDTH cycles from start to the done pulse.
module mod_mul_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_r, b_r, m_r, acc, red1, acc_n;
  logic [WIDTH:0]   dbl, sum;
  logic [IW-1:0]    bit_idx;
  logic             running;

  // acc < m keeps both 2*acc and red1 + a below 2m, so one subtract each suffices.
  always_comb begin
    dbl   = {acc, 1'b0};
    red1  = (dbl >= {1'b0, m_r}) ? WIDTH'(dbl - {1'b0, m_r}) : dbl[WIDTH-1:0];
    sum   = {1'b0, red1} + (b_r[bit_idx] ? {1'b0, a_r} : '0);
    acc_n = (sum >= {1'b0, m_r}) ? WIDTH'(sum - {1'b0, m_r}) : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_r     <= '0;
      b_r     <= '0;
      m_r     <= '0;
      acc     <= '0;
      bit_idx <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r     <= a;
        b_r     <= b;
        m_r     <= m;
        acc     <= '0;
        bit_idx <= IW'(WIDTH - 1);
        running <= 1'b1;
      end else if (running) begin
        acc <= acc_n;
        if (bit_idx == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          bit_idx <= bit_idx - 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply modular exponentiator built around one
// serial modular multiplier; leading exponent zeros are skipped.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ready_in,
  input  logic                 abort_in,
  input  logic [WIDTH-1:0]     value_in,
  input  logic [WIDTH-1:0]     modulus_in,
  input  logic [EXP_WIDTH-1:0] exponent_in,
  output logic [WIDTH-1:0]     value_out,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic                 error_out
);

  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_t               state, state_n;
  op_sel_t              op_sel;
  logic [WIDTH-1:0]     base_r, mod_r, acc, mm_a, mm_b, mm_result;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [KW-1:0]        idx, msb;
  logic                 issued, mm_start, mm_clear, mm_done, op_active, special;

  always_comb begin
    msb = '0;
    for (int j = 0; j < EXP_WIDTH; j++)
      if (exponent_in[j]) msb = KW'(j);
  end

  assign special   = (modulus_in == '0) || (exponent_in == '0);
  assign op_active = (state == REDUCE) || (state == SQUARE) || (state == MULT);
  assign mm_clear  = op_active && abort_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mm_start = 1'b0;
    case (state)
      IDLE:   if (ready_in) state_n = special ? DONE : REDUCE;
      REDUCE: begin
        mm_start = !issued;
        if (mm_done) state_n = (idx == '0) ? DONE : SQUARE;
      end
      SQUARE: begin
        mm_start = !issued;
        if (mm_done) state_n = exp_r[idx] ? MULT : ((idx == '0) ? DONE : SQUARE);
      end
      MULT: begin
        mm_start = !issued;
        if (mm_done) state_n = (idx == '0) ? DONE : SQUARE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (mm_clear) begin
      state_n  = IDLE;
      mm_start = 1'b0;
    end
  end

  // Reduction multiplies the raw base by 1 (0 when m==1 so a < m still holds).
  always_comb begin
    op_sel = OP_REDUCE;
    mm_a   = '0;
    mm_b   = '0;
    case (state)
      SQUARE:  op_sel = OP_SQUARE;
      MULT:    op_sel = OP_MULT;
      default: op_sel = OP_REDUCE;
    endcase
    case (op_sel)
      OP_SQUARE: begin mm_a = acc; mm_b = acc; end
      OP_MULT:   begin mm_a = acc; mm_b = base_r; end
      default: begin
        mm_a = (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
        mm_b = base_r;
      end
    endcase
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (mm_clear),
    .start  (mm_start),
    .a      (mm_a),
    .b      (mm_b),
    .m      (mod_r),
    .done   (mm_done),
    .result (mm_result)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_r    <= '0;
      mod_r     <= '0;
      exp_r     <= '0;
      acc       <= '0;
      idx       <= '0;
      issued    <= 1'b0;
      value_out <= '0;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: if (ready_in) begin
          base_r    <= value_in;
          mod_r     <= modulus_in;
          exp_r     <= exponent_in;
          idx       <= msb;
          issued    <= 1'b0;
          busy_out  <= 1'b1;
          error_out <= 1'b0;
          // Special-case result; overwritten by REDUCE on the normal path.
          acc       <= WIDTH'(modulus_in > WIDTH'(1));
        end
        REDUCE, SQUARE, MULT: begin
          if (abort_in) begin
            busy_out <= 1'b0;
            issued   <= 1'b0;
          end else begin
            if (mm_start) issued <= 1'b1;
            if (mm_done) begin
              acc    <= mm_result;
              issued <= 1'b0;
              if (state == REDUCE) base_r <= mm_result;
              if (idx != '0 && !(state == SQUARE && exp_r[idx]))
                idx <= idx - 1'b1;
            end
          end
        end
        DONE: begin
          value_out <= acc;
          valid_out <= 1'b1;
          busy_out  <= 1'b0;
          error_out <= (mod_r == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine: 16-bit instance for directed cases,
// 24/32-bit instance for a short regression against a modpow model.
module tb_mod_exp_engine;
  import mod_exp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ready, abort, busy, valid, err;
  logic [15:0] v, m, e, q;
  logic        r_ready, r_abort, r_busy, r_valid, r_err;
  logic [23:0] r_v, r_m, r_q;
  logic [31:0] r_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, t0r;

  always @(posedge clk) cyc <= cyc + 1;

  mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut (
    .clk_in(clk), .rst_in(rst), .ready_in(ready), .abort_in(abort),
    .value_in(v), .modulus_in(m), .exponent_in(e),
    .value_out(q), .busy_out(busy), .valid_out(valid), .error_out(err));

  mod_exp_engine #(.WIDTH(24), .EXP_WIDTH(32)) dut24 (
    .clk_in(clk), .rst_in(rst), .ready_in(r_ready), .abort_in(r_abort),
    .value_in(r_v), .modulus_in(r_m), .exponent_in(r_e),
    .value_out(r_q), .busy_out(r_busy), .valid_out(r_valid), .error_out(r_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] modpow(input logic [63:0] b, input logic [63:0] ex,
                                         input logic [63:0] md, input int ew);
    logic [63:0] r, bb;
    if (md == 0) return 0;
    r  = 1 % md;
    bb = b % md;
    for (int j = ew - 1; j >= 0; j--) begin
      r = (r * r) % md;
      if (ex[j]) r = (r * bb) % md;
    end
    return r;
  endfunction

  function automatic int msb_of(input logic [63:0] x);
    int k = 0;
    for (int j = 0; j < 64; j++) if (x[j]) k = j;
    return k;
  endfunction

  function automatic int exp_lat(input int w, input logic [63:0] md, input logic [63:0] ex);
    return int'(cycle_cost(w, msb_of(ex), $countones(ex), (md == 0) || (ex == 0)));
  endfunction

  task automatic start16(input logic [15:0] bv, input logic [15:0] mv, input logic [15:0] ev);
    @(negedge clk);
    v = bv; m = mv; e = ev; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait16(output int lat);
    while (!valid && (cyc - t0) < 4000) begin @(posedge clk); #1; end
    lat = valid ? cyc - t0 : -1;
  endtask

  task automatic run16(input string tag, input logic [15:0] bv, input logic [15:0] mv,
                       input logic [15:0] ev, input logic [15:0] exp_q,
                       input int exp_l, input logic exp_err);
    int lat;
    start16(bv, mv, ev);
    chk({tag, " busy_after_accept"}, busy, 1);
    wait16(lat);
    chk({tag, " value"}, q, exp_q);
    chk({tag, " latency"}, lat, exp_l);
    chk({tag, " busy_at_valid"}, busy, 0);
    chk({tag, " error"}, err, exp_err);
    @(posedge clk); #1;
    chk({tag, " valid_pulse"}, valid, 0);
  endtask

  task automatic run24(input string tag, input logic [23:0] bv, input logic [23:0] mv,
                       input logic [31:0] ev);
    int lat;
    @(negedge clk);
    r_v = bv; r_m = mv; r_e = ev; r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    t0r = cyc - 1;
    while (!r_valid && (cyc - t0r) < 4000) begin @(posedge clk); #1; end
    lat = r_valid ? cyc - t0r : -1;
    chk({tag, " value"}, r_q, modpow(bv, ev, mv, 32));
    chk({tag, " latency"}, lat, exp_lat(24, mv, ev));
    chk({tag, " busy"}, r_busy, 0);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [23:0] bv, mv;
    logic [31:0] ev;
    ready = 0; abort = 0; v = 0; m = 0; e = 0;
    r_ready = 0; r_abort = 0; r_v = 0; r_m = 0; r_e = 0;

    #2;
    chk("reset value", q, 0);
    chk("reset busy", busy, 0);
    chk("reset valid", valid, 0);
    chk("reset error", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run16("pow13",    16'd4,    16'd497,  16'd13, 16'd445, 110, 1'b0);
    run16("big_base", 16'd1000, 16'd7,    16'd2,  16'd1,   38,  1'b0);
    run16("exp0",     16'd3,    16'd7,    16'd0,  16'd1,   2,   1'b0);
    run16("mod1",     16'd5,    16'd1,    16'd9,  16'd0,   92,  1'b0);
    run16("mod0",     16'd1234, 16'd0,    16'd77, 16'd0,   2,   1'b1);
    run16("clr_err",  16'd2,    16'd1000, 16'd10, 16'd24,  92,  1'b0);

    // Abort in the first SQUARE (cycles 19..36 after the sample cycle).
    start16(16'hFFFF, 16'd65521, 16'hFFFF);
    repeat (24) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort valid", valid, 0);
    chk("abort value_kept", q, 24);
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (valid) seen = 1'b1; end
    chk("abort no_valid", seen, 0);
    run16("after_abort", 16'hFFFF, 16'd65521, 16'hFFFF,
          16'(modpow(64'hFFFF, 64'hFFFF, 64'd65521, 16)),
          exp_lat(16, 64'd65521, 64'hFFFF), 1'b0);

    // Re-pulse with different operands while busy: must be ignored.
    start16(16'd7, 16'd11, 16'd5);
    repeat (10) @(posedge clk);
    @(negedge clk); v = 16'd3; m = 16'd13; e = 16'd2; ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    wait16(lat);
    chk("repulse value", q, 10);
    chk("repulse latency", lat, 74);

    // Asynchronous reset mid-operation.
    start16(16'd4, 16'd497, 16'd13);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst value", q, 0);
    chk("midrst busy", busy, 0);
    chk("midrst valid", valid, 0);
    chk("midrst error", err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (120) begin @(posedge clk); #1; if (valid) seen = 1'b1; end
    chk("midrst no_valid", seen, 0);

    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        bv = 24'hFFFFFF; mv = 24'hFFFFFD; ev = 32'hFFFFFFFF;
      end else begin
        bv = 24'($urandom);
        mv = 24'($urandom_range(2, 32'hFFFFFF));
        ev = $urandom;
      end
      run24($sformatf("reg%0d", i), bv, mv, ev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
